// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage in front of the single-instruction datapath. It owns the PC,
// issues one instruction-ROM read per rom_select, and latches the returned word.
// When a read gets no rom_ack within TIMEOUT_CYCLES cycles, the unit enters a
// sticky ERROR state that only reset clears.
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined   : a taken branch to a non-word-aligned target traps. The PC is
//               not updated, misaligned is set and held, and further fetches
//               are blocked.
//   undefined : the low two bits of the target are cleared. misaligned is
//               tied to 0.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   rom_select      fetch request from control FSM
//   pc_write        PC update strobe from control FSM
//   branch_taken    select branch_target instead of pc+4 on pc_write
//   branch_target   branch/jump destination
//   rom_req         ROM read request, held until ack or timeout
//   rom_addr        ROM byte address captured at request time
//   rom_ack         ROM data valid pulse
//   rom_data        ROM read data
//   instruction     latched instruction word (NOP after reset/timeout)
//   pc              current program counter
//   pc_next         pc + 4 (combinational)
//   fetch_busy      a ROM read is outstanding
//   fetch_error     sticky ROM-timeout flag
//   misaligned      sticky misaligned-target flag
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rom_select,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        rom_req,
    output logic [31:0] rom_addr,
    input  logic        rom_ack,
    input  logic [31:0] rom_data,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        fetch_busy,
    output logic        fetch_error,
    output logic        misaligned
);

    localparam int unsigned      CNT_W    = 8;
    localparam logic [31:0]      NOP      = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_req, w_req_nxt;
    logic [31:0]        r_addr, w_addr_nxt;
    logic [31:0]        r_instr, w_instr_nxt;
    logic [31:0]        r_pc, w_pc_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_err, w_err_nxt;
    logic               w_fetch_ok;
`ifdef MISALIGN_TRAP_EN
    logic               r_mis, w_mis_nxt;
    // A pending misalignment trap blocks new fetches
    assign w_fetch_ok = ~r_mis;
`else
    assign w_fetch_ok = 1'b1;
`endif

    // Next-state and next-value logic
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_instr_nxt = r_instr;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
`ifdef MISALIGN_TRAP_EN
        w_mis_nxt   = r_mis;
`endif

        unique case (r_state)
            S_IDLE: begin
                if (rom_select && w_fetch_ok) begin
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_pc;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rom_ack) begin
                    w_instr_nxt = rom_data;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_instr_nxt = NOP;
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_ERROR;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                // ERROR is absorbing; everything stays frozen until reset
            end
        endcase

        // PC update is independent of the in-flight read because rom_addr is latched
        if (pc_write && (r_state != S_ERROR)) begin
            if (!branch_taken) begin
                w_pc_nxt = r_pc + 32'd4;
            end else begin
`ifdef MISALIGN_TRAP_EN
                if (branch_target[1:0] != 2'b00) begin
                    w_mis_nxt = 1'b1;
                end else begin
                    w_pc_nxt = branch_target;
                end
`else
                w_pc_nxt = branch_target & 32'hFFFF_FFFC;
`endif
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
            r_instr <= NOP;
            r_pc    <= RESET_PC;
            r_cnt   <= '0;
            r_err   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_mis   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
            r_instr <= w_instr_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
`ifdef MISALIGN_TRAP_EN
            r_mis   <= w_mis_nxt;
`endif
        end
    end

    assign rom_req     = r_req;
    assign rom_addr    = r_addr;
    assign instruction = r_instr;
    assign pc          = r_pc;
    assign pc_next     = r_pc + 32'd4;
    assign fetch_busy  = (r_state == S_WAIT);
    assign fetch_error = r_err;
`ifdef MISALIGN_TRAP_EN
    assign misaligned  = r_mis;
`else
    assign misaligned  = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed scenario tasks followed by a randomized run checked against a
// behavioural fetch-stage model. Build with MISALIGN_TRAP_EN to match the RTL.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TMO      = 16;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        rom_select;
    logic        pc_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        fetch_busy;
    logic        fetch_error;
    logic        misaligned;

    int n_checks = 0;
    int n_pass   = 0;

    instruction_fetch_unit #(
        .RESET_PC      (RESET_PC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rom_select   (rom_select),
        .pc_write     (pc_write),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .rom_req      (rom_req),
        .rom_addr     (rom_addr),
        .rom_ack      (rom_ack),
        .rom_data     (rom_data),
        .instruction  (instruction),
        .pc           (pc),
        .pc_next      (pc_next),
        .fetch_busy   (fetch_busy),
        .fetch_error  (fetch_error),
        .misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are stable when this returns
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rom_select    = 1'b0;
        pc_write      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        rom_ack       = 1'b0;
        rom_data      = 32'h0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] target);
        pc_write = 1'b1; branch_taken = 1'b1; branch_target = target;
        tick();
        pc_write = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (pc !== RESET_PC) $display("FAIL reset_pc got %h exp %h", pc, RESET_PC); else n_pass++;
        n_checks++; if (rom_addr !== RESET_PC) $display("FAIL reset_rom_addr got %h exp %h", rom_addr, RESET_PC); else n_pass++;
        n_checks++; if (rom_req !== 1'b0) $display("FAIL reset_rom_req got %b exp 0", rom_req); else n_pass++;
        n_checks++; if (instruction !== NOP) $display("FAIL reset_instr got %h exp %h", instruction, NOP); else n_pass++;
        n_checks++; if ({fetch_busy, fetch_error, misaligned} !== 3'b000)
            $display("FAIL reset_flags got %b exp 000", {fetch_busy, fetch_error, misaligned}); else n_pass++;
    endtask

    task automatic test_basic_fetch();
        int busy_cycles;
        apply_reset();
        rom_select = 1'b1;
        tick();
        rom_select = 1'b0;
        n_checks++; if (rom_req !== 1'b1) $display("FAIL fetch_req_rise got %b exp 1", rom_req); else n_pass++;
        n_checks++; if (rom_addr !== 32'h0) $display("FAIL fetch_addr got %h exp 0", rom_addr); else n_pass++;
        busy_cycles = 0;
        for (int c = 0; c < 8; c++) begin
            if (fetch_busy) busy_cycles++;
            rom_ack  = (c == 1);
            rom_data = (c == 1) ? 32'h0050_0093 : 32'hBAD0_BAD0;
            tick();
            rom_ack = 1'b0;
        end
        n_checks++; if (busy_cycles != 2) $display("FAIL fetch_busy_len got %0d exp 2", busy_cycles); else n_pass++;
        n_checks++; if (instruction !== 32'h0050_0093) $display("FAIL fetch_instr got %h exp 00500093", instruction); else n_pass++;
        n_checks++; if (pc_next !== 32'h4) $display("FAIL fetch_pc_next got %h exp 4", pc_next); else n_pass++;
        n_checks++; if (rom_req !== 1'b0) $display("FAIL fetch_req_drop got %b exp 0", rom_req); else n_pass++;
    endtask

    task automatic test_zero_wait();
        rom_select = 1'b1;
        tick();
        rom_select = 1'b0;
        n_checks++; if (instruction !== 32'h0050_0093) $display("FAIL zw_early got %h exp 00500093", instruction); else n_pass++;
        rom_ack = 1'b1; rom_data = 32'h1234_5678;
        tick();
        rom_ack = 1'b0;
        n_checks++; if (instruction !== 32'h1234_5678) $display("FAIL zw_instr got %h exp 12345678", instruction); else n_pass++;
        n_checks++; if (fetch_busy !== 1'b0) $display("FAIL zw_busy got %b exp 0", fetch_busy); else n_pass++;
    endtask

    task automatic test_pc_wrap();
        set_pc(32'hFFFF_FFFC);
        n_checks++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_setup got %h exp fffffffc", pc); else n_pass++;
        pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
        n_checks++; if (pc !== 32'h0) $display("FAIL wrap_pc got %h exp 0", pc); else n_pass++;
        n_checks++; if (pc_next !== 32'h4) $display("FAIL wrap_pc_next got %h exp 4", pc_next); else n_pass++;
    endtask

    task automatic test_branch_during_wait();
        set_pc(32'h20);
        rom_select = 1'b1;
        tick();
        rom_select = 1'b0;
        pc_write = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        pc_write = 1'b0; branch_taken = 1'b0;
        n_checks++; if (pc !== 32'h40) $display("FAIL bwait_pc got %h exp 40", pc); else n_pass++;
        tick();
        tick();
        n_checks++; if (rom_addr !== 32'h20) $display("FAIL bwait_addr got %h exp 20", rom_addr); else n_pass++;
        rom_ack = 1'b1; rom_data = 32'hC0DE_0020;
        tick();
        rom_ack = 1'b0;
        n_checks++; if (instruction !== 32'hC0DE_0020) $display("FAIL bwait_instr got %h exp c0de0020", instruction); else n_pass++;
        n_checks++; if (pc !== 32'h40) $display("FAIL bwait_pc_after got %h exp 40", pc); else n_pass++;
    endtask

    task automatic test_same_cycle();
        // pc is 0x40 here
        rom_select = 1'b1; pc_write = 1'b1;
        tick();
        rom_select = 1'b0; pc_write = 1'b0;
        n_checks++; if (rom_addr !== 32'h40) $display("FAIL same_addr got %h exp 40", rom_addr); else n_pass++;
        n_checks++; if (pc !== 32'h44) $display("FAIL same_pc got %h exp 44", pc); else n_pass++;
        rom_ack = 1'b1; rom_data = 32'h0000_0040;
        tick();
        rom_ack = 1'b0;
    endtask

    task automatic test_timeout();
        int req_cycles;
        apply_reset();
        set_pc(32'h10);
        rom_select = 1'b1;
        tick();
        rom_select = 1'b0;
        req_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            if (rom_req) req_cycles++;
            tick();
        end
        n_checks++; if (req_cycles != TMO) $display("FAIL tmo_req_len got %0d exp %0d", req_cycles, TMO); else n_pass++;
        n_checks++; if (fetch_error !== 1'b1) $display("FAIL tmo_error got %b exp 1", fetch_error); else n_pass++;
        n_checks++; if (instruction !== NOP) $display("FAIL tmo_instr got %h exp %h", instruction, NOP); else n_pass++;
        n_checks++; if (fetch_busy !== 1'b0) $display("FAIL tmo_busy got %b exp 0", fetch_busy); else n_pass++;
        pc_write = 1'b1; rom_select = 1'b1;
        tick();
        tick();
        pc_write = 1'b0; rom_select = 1'b0;
        n_checks++; if (pc !== 32'h10) $display("FAIL tmo_pc_frozen got %h exp 10", pc); else n_pass++;
        n_checks++; if (rom_req !== 1'b0) $display("FAIL tmo_no_req got %b exp 0", rom_req); else n_pass++;
        apply_reset();
        n_checks++; if (fetch_error !== 1'b0) $display("FAIL tmo_reset_err got %b exp 0", fetch_error); else n_pass++;
        n_checks++; if (pc !== RESET_PC) $display("FAIL tmo_reset_pc got %h exp %h", pc, RESET_PC); else n_pass++;
    endtask

    task automatic test_misaligned();
        apply_reset();
        set_pc(32'h102);
`ifdef MISALIGN_TRAP_EN
        n_checks++; if (pc !== 32'h0) $display("FAIL mis_pc got %h exp 0", pc); else n_pass++;
        n_checks++; if (misaligned !== 1'b1) $display("FAIL mis_flag got %b exp 1", misaligned); else n_pass++;
        rom_select = 1'b1;
        tick();
        rom_select = 1'b0;
        n_checks++; if (rom_req !== 1'b0) $display("FAIL mis_blocked got %b exp 0", rom_req); else n_pass++;
`else
        n_checks++; if (pc !== 32'h100) $display("FAIL mis_pc got %h exp 100", pc); else n_pass++;
        n_checks++; if (misaligned !== 1'b0) $display("FAIL mis_flag got %b exp 0", misaligned); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_fetch();
        apply_reset();
        set_pc(32'h80);
        rom_select = 1'b1;
        tick();
        rom_select = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rom_ack = 1'b1; rom_data = 32'hDEAD_BEEF;
        tick();
        rom_ack = 1'b0;
        n_checks++; if (instruction !== NOP) $display("FAIL rmid_instr got %h exp %h", instruction, NOP); else n_pass++;
        n_checks++; if (fetch_busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", fetch_busy); else n_pass++;
        n_checks++; if (rom_req !== 1'b0) $display("FAIL rmid_req got %b exp 0", rom_req); else n_pass++;
        n_checks++; if (pc !== RESET_PC) $display("FAIL rmid_pc got %h exp %h", pc, RESET_PC); else n_pass++;
    endtask

    // Randomized run against a behavioural model of the fetch stage
    task automatic test_random();
        logic [31:0] m_pc, m_addr, m_instr;
        bit          m_pending, m_err, m_mis;
        int          m_waited;
        int          errs;
        apply_reset();
        m_pc = RESET_PC; m_addr = RESET_PC; m_instr = NOP;
        m_pending = 0; m_err = 0; m_mis = 0; m_waited = 0;
        errs = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            n_checks++;
            if (pc !== m_pc || rom_addr !== m_addr || instruction !== m_instr || rom_req !== m_pending ||
                fetch_busy !== m_pending || fetch_error !== m_err || misaligned !== m_mis ||
                pc_next !== m_pc + 32'd4) begin
                if (errs < 10)
                    $display("FAIL rand_cyc%0d got pc=%h addr=%h ins=%h req=%b busy=%b err=%b mis=%b exp pc=%h addr=%h ins=%h req=%b err=%b mis=%b",
                             cyc, pc, rom_addr, instruction, rom_req, fetch_busy, fetch_error, misaligned,
                             m_pc, m_addr, m_instr, m_pending, m_err, m_mis);
                errs++;
            end else n_pass++;

            reset         = ($urandom_range(0, 99) == 0);
            rom_select    = ($urandom_range(0, 1) == 1);
            pc_write      = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 1) == 1);
            branch_target = $urandom;
            if ($urandom_range(0, 3) != 0) branch_target[1:0] = 2'b00;
            rom_ack       = ($urandom_range(0, 7) == 0);
            rom_data      = $urandom;

            if (reset) begin
                m_pc = RESET_PC; m_addr = RESET_PC; m_instr = NOP;
                m_pending = 0; m_err = 0; m_mis = 0; m_waited = 0;
            end else if (!m_err) begin
                if (m_pending) begin
                    m_waited++;
                    if (rom_ack) begin
                        m_instr = rom_data; m_pending = 0;
                    end else if (m_waited == TMO) begin
                        m_instr = NOP; m_pending = 0; m_err = 1;
                    end
                end else if (rom_select && !m_mis) begin
                    m_pending = 1; m_addr = m_pc; m_waited = 0;
                end
                if (pc_write) begin
                    if (!branch_taken) m_pc = m_pc + 32'd4;
`ifdef MISALIGN_TRAP_EN
                    else if (branch_target % 4 != 0) m_mis = 1;
                    else m_pc = branch_target;
`else
                    else m_pc = branch_target - (branch_target % 4);
`endif
                end
            end
            tick();
        end
        clear_inputs();
        reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_basic_fetch();
        test_zero_wait();
        test_pc_wrap();
        test_branch_during_wait();
        test_same_cycle();
        test_timeout();
        test_misaligned();
        test_reset_mid_fetch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
